simple_circuit_pipe: RTL and testbench

- Clocked, parametrised successor to the gate-delay simple circuit.
- Computes D = (A & B) | ~C and E = ~C bitwise over WIDTH-bit channels.
- Gate propagation delays are replaced by per-output pipeline latencies in clock cycles.
- Adds a valid/ready handshake with backpressure, a synchronous flush and a saturating result counter. Used as a reusable timed-logic datapath element in simulation labs.

---
 rtl/simple_circuit_pipe.sv | 118 +++++++++++
 tb/tb_simple_circuit_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/simple_circuit_pipe.sv
// Purpose: pipelined timed-logic element, D = (A & B) | ~C and E = ~C over WIDTH channels.
// Latency: D after D_LAT cycles, E after E_LAT cycles (D_LAT with SIMPLE_CIRCUIT_ALIGN_EN), plus one per stall cycle.
// Backpressure: out_ready low with any output valid freezes both pipelines and drops in_ready.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   clr             synchronous flush of both pipelines and the result counter
//   in_valid/in_ready, A, B, C   input sample handshake and operands
//   out_ready       consumer takes D and E together
//   D/d_valid, E/e_valid         results, forced to 0 when not valid
//   count           saturating number of delivered D results
//
// Optional macro SIMPLE_CIRCUIT_ALIGN_EN: E pipeline is D_LAT deep so D and E of a
// sample leave together and E_LAT is ignored.
module simple_circuit_pipe #(
  parameter int WIDTH = 4,
  parameter int D_LAT = 3,
  parameter int E_LAT = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             d_valid,
  output logic [WIDTH-1:0] E,
  output logic             e_valid,
  output logic [CNT_W-1:0] count
);

`ifdef SIMPLE_CIRCUIT_ALIGN_EN
  localparam int E_DEPTH = D_LAT;
`else
  localparam int E_DEPTH = E_LAT;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [D_LAT-1:0][WIDTH-1:0]   d_dat;
  logic [D_LAT-1:0]              d_vld;
  logic [E_DEPTH-1:0][WIDTH-1:0] e_dat;
  logic [E_DEPTH-1:0]            e_vld;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] d_fn;
  logic [WIDTH-1:0] e_fn;

  assign d_fn = (A & B) | ~C;
  assign e_fn = ~C;

  assign d_valid = d_vld[D_LAT-1];
  assign e_valid = e_vld[E_DEPTH-1];

  // Output words are gated by their valid bit, so the data registers
  // themselves never need a reset value.
  assign D = d_valid ? d_dat[D_LAT-1]   : '0;
  assign E = e_valid ? e_dat[E_DEPTH-1] : '0;

  // Both pipelines freeze together whenever something is parked at the
  // output, even if only one of D/E is valid, so the two streams never slip.
  assign stall    = ~out_ready & (d_valid | e_valid);
  assign in_ready = ~stall & ~clr;
  assign accept   = in_valid & in_ready;

  // Valid bits: reset and flushable; bubbles shift through uncompressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_vld <= '0;
      e_vld <= '0;
    end else if (clr) begin
      d_vld <= '0;
      e_vld <= '0;
    end else if (!stall) begin
      for (int i = D_LAT - 1; i > 0; i--) begin
        d_vld[i] <= d_vld[i-1];
      end
      d_vld[0] <= accept;
      for (int i = E_DEPTH - 1; i > 0; i--) begin
        e_vld[i] <= e_vld[i-1];
      end
      e_vld[0] <= accept;
    end
  end

  // Data words: shift alongside the valid bits; contents under a zero valid
  // bit are don't-care, so clr need not touch them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = D_LAT - 1; i > 0; i--) begin
        d_dat[i] <= d_dat[i-1];
      end
      d_dat[0] <= d_fn;
      for (int i = E_DEPTH - 1; i > 0; i--) begin
        e_dat[i] <= e_dat[i-1];
      end
      e_dat[0] <= e_fn;
    end
  end

  // Delivered-result counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (d_valid && out_ready && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_simple_circuit_pipe.sv
// Purpose: directed self-checking bench for simple_circuit_pipe (default and CNT_W=3 instances).
// Latency: expectations derived from D_LAT=3 and E_LAT=1 (3 with SIMPLE_CIRCUIT_ALIGN_EN).
// Backpressure: exercised with a 4-cycle out_ready=0 window in the 6-sample stream.
module tb_simple_circuit_pipe;

  localparam int DL = 3;
`ifdef SIMPLE_CIRCUIT_ALIGN_EN
  localparam int EL = 3;
`else
  localparam int EL = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A, B, C;
  logic       out_ready;
  logic [3:0] D, E;
  logic       d_valid, e_valid;
  logic [7:0] count;

  logic       s_in_ready;
  logic [3:0] s_D, s_E;
  logic       s_d_valid, s_e_valid;
  logic [2:0] s_count;

  int n_checks = 0;
  int n_errors = 0;
  int total    = 0;   // D results delivered since the last reset/flush

  // Hand-computed stream table: D = (A & B) | ~C, E = ~C.
  logic [3:0] sa [6] = '{4'h3, 4'hF, 4'h0, 4'hC, 4'h6, 4'h9};
  logic [3:0] sb [6] = '{4'h5, 4'hF, 4'h0, 4'hA, 4'h6, 4'h3};
  logic [3:0] sc [6] = '{4'hF, 4'hF, 4'h8, 4'h3, 4'hE, 4'h5};
  logic [3:0] sd [6] = '{4'h1, 4'hF, 4'h7, 4'hC, 4'h7, 4'hB};
  logic [3:0] se [6] = '{4'h0, 4'h0, 4'h7, 4'hC, 4'h1, 4'hA};

  simple_circuit_pipe #(.WIDTH(4), .D_LAT(DL), .E_LAT(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C),
    .out_ready(out_ready),
    .D(D), .d_valid(d_valid), .E(E), .e_valid(e_valid),
    .count(count)
  );

  simple_circuit_pipe #(.WIDTH(4), .D_LAT(DL), .E_LAT(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .A(A), .B(B), .C(C),
    .out_ready(out_ready),
    .D(s_D), .d_valid(s_d_valid), .E(s_E), .e_valid(s_e_valid),
    .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(total));
    chk({tag, "_sat_count"}, 32'(s_count), (total > 7) ? 32'd7 : 32'(total));
  endtask

  // One isolated sample: checks D/E value and valid every cycle around the latency.
  task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] dexp, input logic [3:0] eexp, input string tag);
    A = a; B = b; C = c; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= DL + 2; k++) begin
      chk($sformatf("%s_D_k%0d", tag, k), 32'(D), (k == DL) ? 32'(dexp) : 32'd0);
      chk($sformatf("%s_dv_k%0d", tag, k), 32'(d_valid), (k == DL) ? 32'd1 : 32'd0);
      chk($sformatf("%s_E_k%0d", tag, k), 32'(E), (k == EL) ? 32'(eexp) : 32'd0);
      chk($sformatf("%s_ev_k%0d", tag, k), 32'(e_valid), (k == EL) ? 32'd1 : 32'd0);
      tick();
    end
    total++;
    chk_counts(tag);
  endtask

  // Stream n table samples; once D first appears, hold out_ready low for stall_len cycles.
  task automatic run_stream(input int n, input int stall_len, input string tag);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    logic exp_rdy;
    logic [3:0] dq[$];
    logic [3:0] eq[$];
    while (got < n && cyc < 80) begin
      if (d_valid) begin
        if (dq.size() == 0) chk({tag, "_D_unexpected"}, 32'(D), 32'hDEAD);
        else chk($sformatf("%s_D_c%0d", tag, cyc), 32'(D), 32'(dq[0]));
      end
      if (e_valid) begin
        if (eq.size() == 0) chk({tag, "_E_unexpected"}, 32'(E), 32'hDEAD);
        else chk($sformatf("%s_E_c%0d", tag, cyc), 32'(E), 32'(eq[0]));
      end
      if (!stalled && d_valid && stall_len > 0) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (out_ready && d_valid && dq.size() > 0) begin
        void'(dq.pop_front());
        got++;
        total++;
      end
      if (out_ready && e_valid && eq.size() > 0) void'(eq.pop_front());
      exp_rdy = out_ready | ~(d_valid | e_valid);
      in_valid = (sent < n);
      if (sent < n) begin
        A = sa[sent]; B = sb[sent]; C = sc[sent];
      end
      #1 chk($sformatf("%s_in_ready_c%0d", tag, cyc), 32'(in_ready), 32'(exp_rdy));
      if (in_valid && exp_rdy) begin
        dq.push_back(sd[sent]);
        eq.push_back(se[sent]);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_delivered"}, 32'(got), 32'(n));
    chk({tag, "_e_left"}, 32'(eq.size()), 32'd0);
    chk({tag, "_stalled"}, 32'(stalled), (stall_len > 0) ? 32'd1 : 32'd0);
    tick();
    chk_counts(tag);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 4'h0; B = 4'h0; C = 4'h0;
    #3;
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_E", 32'(E), 32'd0);
    chk("rst_dv", 32'(d_valid), 32'd0);
    chk("rst_ev", 32'(e_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    single(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, "zero");
    single(4'hF, 4'h5, 4'hE, 4'h5, 4'h1, "one");

    run_stream(5, 0, "stream5");
    run_stream(6, 4, "stall6");
    chk("sat_pinned", 32'(s_count), 32'd7);

    // Flush mid-stream: two samples in flight, then clr.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      A = sa[i]; B = sb[i]; C = sc[i]; in_valid = 1'b1;
      tick();
    end
    clr = 1'b1;
    #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    total = 0;
    chk("clr_dv", 32'(d_valid), 32'd0);
    chk("clr_ev", 32'(e_valid), 32'd0);
    chk_counts("clr");
    for (int k = 0; k < DL + 1; k++) begin
      chk($sformatf("clr_stale_dv_%0d", k), 32'(d_valid), 32'd0);
      chk($sformatf("clr_stale_ev_%0d", k), 32'(e_valid), 32'd0);
      tick();
    end
    chk_counts("clr_after");

    // Asynchronous reset mid-stream, with a result on the output.
    for (int i = 0; i < 4; i++) begin
      A = sa[i]; B = sb[i]; C = sc[i]; in_valid = 1'b1;
      tick();
    end
    total = 1;
    chk("pre_rst_dv", 32'(d_valid), 32'd1);
    chk_counts("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    total = 0;
    chk("arst_D", 32'(D), 32'd0);
    chk("arst_E", 32'(E), 32'd0);
    chk("arst_dv", 32'(d_valid), 32'd0);
    chk("arst_ev", 32'(e_valid), 32'd0);
    chk_counts("arst");
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < DL + 1; k++) begin
      tick();
      chk($sformatf("arst_stale_dv_%0d", k), 32'(d_valid), 32'd0);
      chk($sformatf("arst_stale_ev_%0d", k), 32'(e_valid), 32'd0);
    end
    single(4'hF, 4'h5, 4'hE, 4'h5, 4'h1, "resume");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
